gen_reg_ctrl: RTL and testbench
===============================

Name: gen_reg_ctrl

Overview:
Command sequencer that acts as the initiator side of the general register file port. It accepts register operations over a valid/ready command channel and drives the register file's address, field-select, write-enable and write data. It captures the file's read data and returns results over a valid/ready response channel. It sits between the instruction decode/execute logic and the 6-entry, 20-bit general register file.

Parameters:
WORD_W, 20, register word width
HALF_W, 10, half-word width (WORD_W/2)
NUM_REGS, 6, number of implemented registers; addresses >= NUM_REGS are illegal
ADDR_W, 10, register address width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller idle and accepting a command
cmd_op  input  3  000 NOP, 001 WRITE, 010 READ, 011 MOVE, 100 SWAP, others illegal
cmd_sel  input  2  field: 00 full word, 01 high half [19:10], 10 low half [9:0], 11 illegal
cmd_ra  input  ADDR_W  primary register (write/read target; MOVE source; SWAP first)
cmd_rb  input  ADDR_W  secondary register (MOVE destination; SWAP second)
cmd_data  input  WORD_W  WRITE data; half writes use [HALF_W-1:0]
rsp_valid  output  1  response present
rsp_ready  input  1  response accepted
rsp_data  output  WORD_W  READ result; half reads zero-extended into [HALF_W-1:0]; 0 otherwise
rsp_err  output  1  command rejected, no register-file access made
rf_addr  output  ADDR_W  register file address
rf_addr_sel  output  2  register file field select (cmd_sel registered)
rf_we  output  1  register file write strobe, one cycle
rf_data_in  output  WORD_W  write data, value placed in addressed half, other half 0
rf_data_out  input  WORD_W  register file read data, valid one cycle after rf_addr is presented

Behaviour:
- Reset (async, immediate): state IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, rf_we=0, rf_addr=0, rf_addr_sel=0, rf_data_in=0. All internal capture registers are cleared.
- cmd_ready=1 only in IDLE. The command is accepted on an edge with cmd_valid&&cmd_ready, and all cmd_* fields are registered then.
- Each FSM state lasts exactly one cycle, except RESP.
- State sequence by op:
  - NOP: IDLE->RESP.
  - WRITE: IDLE->WR_A->RESP.
  - READ: IDLE->RD_A->WAIT_A->RESP.
  - MOVE: IDLE->RD_A->WAIT_A->WR_B->RESP.
  - SWAP: IDLE->RD_A->WAIT_A->RD_B->WAIT_B->WR_A->WR_B->RESP.
- RD_x: drive rf_addr to that register and rf_addr_sel to the field. In WAIT_x, capture rf_data_out into tmp_x at the end of the cycle; the field is extracted and right-justified.
- WR_x: rf_we=1 and rf_addr=target. rf_data_in carries the value: full word as-is; high half shifted to [19:10] with low half zero; low half in [9:0] with high half zero.
- MOVE writes the src field value to the same field of dst. SWAP writes tmp_b to ra, then tmp_a to rb.
- Latency from accept edge to rsp_valid rising: NOP 1, WRITE 2, READ 3, MOVE 4, SWAP 7.
- RESP: rsp_valid=1, and rsp_data/rsp_err are held stable until rsp_ready. On the rsp_valid&&rsp_ready edge, the controller returns to IDLE. The next command is accepted no earlier than the following edge; there is no back-to-back accept.
- Error check at accept: illegal op, sel=11, ra>=NUM_REGS, or rb>=NUM_REGS for MOVE/SWAP. On error: IDLE->RESP with rsp_err=1, rsp_data=0, and rf_we never asserted.
- ra==rb for MOVE/SWAP is legal. The sequence runs normally and the register value is unchanged.
- rf_we is never high outside WR_A/WR_B. Outside RD/WAIT/WR states, rf_addr/rf_addr_sel hold their last values.
- Reset mid-operation: the sequence is abandoned. A WR in progress at reset assertion is suppressed because rf_we drops asynchronously.

Decomposition:
- Shared package gen_reg_pkg holds:
  - the op encodings (OP_NOP..OP_SWAP);
  - the field encodings (SEL_FULL=00, SEL_HI=01, SEL_LO=10);
  - WORD_W/HALF_W/NUM_REGS constants;
  - the FSM state enum.
- One sub-module, gen_reg_field: combinational pack/unpack of a half-word to and from the selected field. It is used in the WAIT capture path and the WR data path.

Test Plan:
1. WRITE full ra=0, data=0xAAAAA, then READ full ra=0 -> rf_we one cycle with rf_data_in=0xAAAAA; READ rsp_data=0xAAAAA, rsp_err=0, rsp_valid 3 cycles after accept.
2. WRITE high ra=1, data[9:0]=0x333 -> rf_data_in=0xCCC00 with sel=01; READ high ra=1 -> rsp_data=0x00333.
3. MOVE low ra=2 (low=0x0F0) to rb=3 -> one write to reg 3 with rf_data_in=0x000F0 and sel=10; rsp_valid 4 cycles after accept, rsp_data=0.
4. SWAP full with reg4=0x12345 and reg5=0xABCDE -> rf_we at WR_A addr4 data 0xABCDE, then WR_B addr5 data 0x12345; rsp 7 cycles after accept.
5. Illegal cases: ra=6, sel=11, op=111 -> rsp_err=1, rsp_data=0, rf_we stays 0; rsp_valid 1 cycle after accept.
6. Backpressure and reset: hold rsp_ready=0 for 5 cycles, then assert rst during WR_B of a SWAP -> rsp held stable while stalled; rf_we drops immediately on rst; all outputs at reset values; cmd_ready=1 after rst deasserts.

Source files
------------

// File: rtl/gen_reg_pkg.sv
// Shared encodings and sizing for the general register file controller.
// Op, field and FSM state types are used by the controller and the field packer.
package gen_reg_pkg;

    localparam int unsigned WORD_W   = 20;
    localparam int unsigned HALF_W   = WORD_W / 2;
    localparam int unsigned NUM_REGS = 6;
    localparam int unsigned ADDR_W   = 10;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_WRITE = 3'b001,
        OP_READ  = 3'b010,
        OP_MOVE  = 3'b011,
        OP_SWAP  = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        SEL_FULL = 2'b00,
        SEL_HI   = 2'b01,
        SEL_LO   = 2'b10
    } sel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_WAIT_A,
        ST_RD_B,
        ST_WAIT_B,
        ST_WR_A,
        ST_WR_B,
        ST_RESP
    } state_t;

endpackage

// File: rtl/gen_reg_field.sv
// Field packer/unpacker: extracts the selected field right-justified from a
// register word, and places a right-justified value back into that field.
module gen_reg_field
    import gen_reg_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [WORD_W-1:0] word_in,
    input  logic [WORD_W-1:0] val_in,
    output logic [WORD_W-1:0] field_out,
    output logic [WORD_W-1:0] word_out
);

    always_comb begin
        field_out = word_in;
        case (sel)
            SEL_HI:  field_out = {{HALF_W{1'b0}}, word_in[WORD_W-1:HALF_W]};
            SEL_LO:  field_out = {{HALF_W{1'b0}}, word_in[HALF_W-1:0]};
            default: field_out = word_in;
        endcase
    end

    // The unselected half is always driven to zero on packing.
    always_comb begin
        word_out = val_in;
        case (sel)
            SEL_HI:  word_out = {val_in[HALF_W-1:0], {HALF_W{1'b0}}};
            SEL_LO:  word_out = {{HALF_W{1'b0}}, val_in[HALF_W-1:0]};
            default: word_out = val_in;
        endcase
    end

endmodule

// File: rtl/gen_reg_ctrl.sv
// Command sequencer driving the 6-entry general register file port.
// Runs NOP/WRITE/READ/MOVE/SWAP as fixed state sequences and returns a response.
module gen_reg_ctrl
    import gen_reg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [WORD_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [1:0]        rf_addr_sel,
    output logic              rf_we,
    output logic [WORD_W-1:0] rf_data_in,
    input  logic [WORD_W-1:0] rf_data_out
);

    state_t            st, st_nxt;
    logic [2:0]        op_q;
    logic [1:0]        sel_q;
    logic [ADDR_W-1:0] ra_q, rb_q;
    logic [WORD_W-1:0] data_q, tmp_a, tmp_b;
    logic [ADDR_W-1:0] addr_hold;
    logic [1:0]        sel_hold;
    logic [WORD_W-1:0] din_hold;
    logic [WORD_W-1:0] field_val, pack_src, pack_word;
    logic              accept, cmd_err, two_reg;

    assign accept  = cmd_valid && cmd_ready;
    assign two_reg = (cmd_op == OP_MOVE) || (cmd_op == OP_SWAP);

    always_comb begin
        cmd_err = (cmd_op > OP_SWAP)
               || (cmd_sel == 2'b11)
               || (cmd_ra >= ADDR_W'(NUM_REGS))
               || (two_reg && (cmd_rb >= ADDR_W'(NUM_REGS)));
    end

    gen_reg_field u_field (
        .sel       (sel_q),
        .word_in   (rf_data_out),
        .val_in    (pack_src),
        .field_out (field_val),
        .word_out  (pack_word)
    );

    // rf_we/rf_addr are decoded from state so that reset clears the strobe
    // asynchronously; the hold registers keep the port stable between accesses.
    always_comb begin
        st_nxt      = st;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rf_we       = 1'b0;
        rf_addr     = addr_hold;
        rf_addr_sel = sel_hold;
        rf_data_in  = din_hold;
        pack_src    = data_q;
        case (st)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_err) begin
                        st_nxt = ST_RESP;
                    end else begin
                        case (cmd_op)
                            OP_WRITE:                   st_nxt = ST_WR_A;
                            OP_READ, OP_MOVE, OP_SWAP:  st_nxt = ST_RD_A;
                            default:                    st_nxt = ST_RESP;
                        endcase
                    end
                end
            end
            ST_RD_A: begin
                rf_addr     = ra_q;
                rf_addr_sel = sel_q;
                st_nxt      = ST_WAIT_A;
            end
            ST_WAIT_A: begin
                rf_addr     = ra_q;
                rf_addr_sel = sel_q;
                case (op_q)
                    OP_MOVE: st_nxt = ST_WR_B;
                    OP_SWAP: st_nxt = ST_RD_B;
                    default: st_nxt = ST_RESP;
                endcase
            end
            ST_RD_B: begin
                rf_addr     = rb_q;
                rf_addr_sel = sel_q;
                st_nxt      = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                rf_addr     = rb_q;
                rf_addr_sel = sel_q;
                st_nxt      = ST_WR_A;
            end
            ST_WR_A: begin
                pack_src    = (op_q == OP_SWAP) ? tmp_b : data_q;
                rf_we       = 1'b1;
                rf_addr     = ra_q;
                rf_addr_sel = sel_q;
                rf_data_in  = pack_word;
                st_nxt      = (op_q == OP_SWAP) ? ST_WR_B : ST_RESP;
            end
            ST_WR_B: begin
                pack_src    = tmp_a;
                rf_we       = 1'b1;
                rf_addr     = rb_q;
                rf_addr_sel = sel_q;
                rf_data_in  = pack_word;
                st_nxt      = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) st_nxt = ST_IDLE;
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= ST_IDLE;
            op_q      <= '0;
            sel_q     <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            data_q    <= '0;
            tmp_a     <= '0;
            tmp_b     <= '0;
            addr_hold <= '0;
            sel_hold  <= '0;
            din_hold  <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            st        <= st_nxt;
            addr_hold <= rf_addr;
            sel_hold  <= rf_addr_sel;
            din_hold  <= rf_data_in;
            if (accept) begin
                op_q     <= cmd_op;
                sel_q    <= cmd_sel;
                ra_q     <= cmd_ra;
                rb_q     <= cmd_rb;
                data_q   <= cmd_data;
                rsp_err  <= cmd_err;
                rsp_data <= '0;
            end
            if (st == ST_WAIT_A) begin
                tmp_a <= field_val;
                if (op_q == OP_READ) rsp_data <= field_val;
            end
            if (st == ST_WAIT_B) tmp_b <= field_val;
        end
    end

endmodule

// File: tb/tb_gen_reg_ctrl.sv
// Directed bench for gen_reg_ctrl with a behavioural register file model.
module tb_gen_reg_ctrl;
    import gen_reg_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [1:0]        cmd_sel;
    logic [ADDR_W-1:0] cmd_ra, cmd_rb;
    logic [WORD_W-1:0] cmd_data;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [WORD_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rf_addr;
    logic [1:0]        rf_addr_sel;
    logic              rf_we;
    logic [WORD_W-1:0] rf_data_in, rf_data_out;

    int n_cmp = 0;
    int n_bad = 0;

    bit   [WORD_W-1:0] mem [NUM_REGS];
    int                wr_total = 0;
    logic [ADDR_W-1:0] wr_a [64];
    logic [1:0]        wr_s [64];
    logic [WORD_W-1:0] wr_d [64];

    gen_reg_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_sel     (cmd_sel),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rf_addr     (rf_addr),
        .rf_addr_sel (rf_addr_sel),
        .rf_we       (rf_we),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
    );

    always #5 clk = ~clk;

    // Register file model: one-cycle read latency, field-merged writes.
    always @(posedge clk) begin
        if (rf_we && rf_addr < ADDR_W'(NUM_REGS)) begin
            case (rf_addr_sel)
                2'b01:   mem[rf_addr][19:10] <= rf_data_in[19:10];
                2'b10:   mem[rf_addr][9:0]   <= rf_data_in[9:0];
                default: mem[rf_addr]        <= rf_data_in;
            endcase
        end
        rf_data_out <= (rf_addr < ADDR_W'(NUM_REGS)) ? mem[rf_addr] : '0;
    end

    always @(negedge clk) begin
        if (rf_we) begin
            if (wr_total < 64) begin
                wr_a[wr_total] = rf_addr;
                wr_s[wr_total] = rf_addr_sel;
                wr_d[wr_total] = rf_data_in;
            end
            wr_total = wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] sel,
                          input logic [9:0] ra, input logic [9:0] rb,
                          input logic [19:0] data,
                          output int lat, output logic [19:0] rdata,
                          output logic rerr, output int base);
        base      = wr_total;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_data  = data;
        cmd_valid = 1'b1;
        check("ready_before_accept", 32'(cmd_ready), 32'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_data;
        rerr  = rsp_err;
        @(posedge clk); #1;
    endtask

    int          lat, base;
    logic [19:0] rd;
    logic        er;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_sel = '0;
        cmd_ra = '0; cmd_rb = '0; cmd_data = '0; rsp_ready = 1'b1;
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rf_we",     32'(rf_we),     32'h0);
        check("rst_rf_addr",   32'(rf_addr),   32'h0);
        check("rst_rsp_data",  32'(rsp_data),  32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // WRITE full then READ full
        do_cmd(OP_WRITE, 2'b00, 10'd0, 10'd0, 20'hAAAAA, lat, rd, er, base);
        check("wr_lat",   32'(lat), 32'd2);
        check("wr_count", 32'(wr_total - base), 32'd1);
        check("wr_data",  32'(wr_d[base]), 32'hAAAAA);
        check("wr_addr",  32'(wr_a[base]), 32'h0);
        check("wr_err",   32'(er), 32'h0);
        do_cmd(OP_READ, 2'b00, 10'd0, 10'd0, 20'h0, lat, rd, er, base);
        check("rd_lat",   32'(lat), 32'd3);
        check("rd_data",  32'(rd),  32'hAAAAA);
        check("rd_err",   32'(er),  32'h0);
        check("rd_nowr",  32'(wr_total - base), 32'd0);

        // High-half write and read
        do_cmd(OP_WRITE, 2'b01, 10'd1, 10'd0, 20'h00333, lat, rd, er, base);
        check("wrhi_data", 32'(wr_d[base]), 32'hCCC00);
        check("wrhi_sel",  32'(wr_s[base]), 32'h1);
        do_cmd(OP_READ, 2'b01, 10'd1, 10'd0, 20'h0, lat, rd, er, base);
        check("rdhi_data", 32'(rd), 32'h00333);

        // Preload regs 2..5
        do_cmd(OP_WRITE, 2'b00, 10'd2, 10'd0, 20'h550F0, lat, rd, er, base);
        do_cmd(OP_WRITE, 2'b00, 10'd3, 10'd0, 20'h7FFFF, lat, rd, er, base);
        do_cmd(OP_WRITE, 2'b00, 10'd4, 10'd0, 20'h12345, lat, rd, er, base);
        do_cmd(OP_WRITE, 2'b00, 10'd5, 10'd0, 20'hABCDE, lat, rd, er, base);

        // MOVE low field reg2 -> reg3
        do_cmd(OP_MOVE, 2'b10, 10'd2, 10'd3, 20'h0, lat, rd, er, base);
        check("mv_lat",   32'(lat), 32'd4);
        check("mv_count", 32'(wr_total - base), 32'd1);
        check("mv_addr",  32'(wr_a[base]), 32'h3);
        check("mv_data",  32'(wr_d[base]), 32'h000F0);
        check("mv_sel",   32'(wr_s[base]), 32'h2);
        check("mv_rsp",   32'(rd), 32'h0);
        do_cmd(OP_READ, 2'b00, 10'd3, 10'd0, 20'h0, lat, rd, er, base);
        check("mv_result", 32'(rd), 32'h7FCF0);

        // SWAP full reg4 <-> reg5
        do_cmd(OP_SWAP, 2'b00, 10'd4, 10'd5, 20'h0, lat, rd, er, base);
        check("sw_lat",    32'(lat), 32'd7);
        check("sw_count",  32'(wr_total - base), 32'd2);
        check("sw_a_addr", 32'(wr_a[base]), 32'h4);
        check("sw_a_data", 32'(wr_d[base]), 32'hABCDE);
        check("sw_b_addr", 32'(wr_a[base+1]), 32'h5);
        check("sw_b_data", 32'(wr_d[base+1]), 32'h12345);
        do_cmd(OP_READ, 2'b00, 10'd4, 10'd0, 20'h0, lat, rd, er, base);
        check("sw_rd4", 32'(rd), 32'hABCDE);

        // SWAP with ra==rb leaves the register unchanged
        do_cmd(OP_SWAP, 2'b01, 10'd4, 10'd4, 20'h0, lat, rd, er, base);
        check("swself_lat", 32'(lat), 32'd7);
        check("swself_err", 32'(er), 32'h0);
        do_cmd(OP_READ, 2'b00, 10'd4, 10'd0, 20'h0, lat, rd, er, base);
        check("swself_rd4", 32'(rd), 32'hABCDE);

        // NOP and illegal commands
        do_cmd(OP_NOP, 2'b00, 10'd0, 10'd0, 20'h0, lat, rd, er, base);
        check("nop_lat", 32'(lat), 32'd1);
        check("nop_err", 32'(er), 32'h0);
        do_cmd(OP_WRITE, 2'b00, 10'd6, 10'd0, 20'h11111, lat, rd, er, base);
        check("err_ra_err",  32'(er), 32'h1);
        check("err_ra_lat",  32'(lat), 32'd1);
        check("err_ra_data", 32'(rd), 32'h0);
        check("err_ra_nowr", 32'(wr_total - base), 32'd0);
        do_cmd(OP_WRITE, 2'b11, 10'd0, 10'd0, 20'h22222, lat, rd, er, base);
        check("err_sel_err",  32'(er), 32'h1);
        check("err_sel_nowr", 32'(wr_total - base), 32'd0);
        do_cmd(3'b111, 2'b00, 10'd0, 10'd0, 20'h0, lat, rd, er, base);
        check("err_op_err", 32'(er), 32'h1);
        check("err_op_lat", 32'(lat), 32'd1);
        do_cmd(OP_MOVE, 2'b00, 10'd0, 10'd6, 20'h0, lat, rd, er, base);
        check("err_rb_err",  32'(er), 32'h1);
        check("err_rb_nowr", 32'(wr_total - base), 32'd0);

        // Response backpressure on a READ
        rsp_ready = 1'b0;
        cmd_op = OP_READ; cmd_sel = 2'b00; cmd_ra = 10'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'h1);
            check("bp_data",  32'(rsp_data),  32'hAAAAA);
            check("bp_ready", 32'(cmd_ready), 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(rsp_valid), 32'h0);
        check("bp_release_ready", 32'(cmd_ready), 32'h1);

        // Reset during WR_B of a SWAP
        base = wr_total;
        cmd_op = OP_SWAP; cmd_sel = 2'b00; cmd_ra = 10'd4; cmd_rb = 10'd5; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_we",   32'(rf_we),      32'h1);
        check("mid_addr", 32'(rf_addr),    32'h5);
        check("mid_data", 32'(rf_data_in), 32'hABCDE);
        #2 rst = 1'b1;
        #1;
        check("arst_we",        32'(rf_we),       32'h0);
        check("arst_addr",      32'(rf_addr),     32'h0);
        check("arst_sel",       32'(rf_addr_sel), 32'h0);
        check("arst_din",       32'(rf_data_in),  32'h0);
        check("arst_rsp_valid", 32'(rsp_valid),   32'h0);
        check("arst_rsp_err",   32'(rsp_err),     32'h0);
        check("arst_rsp_data",  32'(rsp_data),    32'h0);
        check("arst_ready",     32'(cmd_ready),   32'h1);
        check("arst_wr_count",  32'(wr_total - base), 32'd1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(cmd_ready), 32'h1);
        do_cmd(OP_READ, 2'b00, 10'd4, 10'd0, 20'h0, lat, rd, er, base);
        check("post_rst_rd4", 32'(rd), 32'h12345);
        do_cmd(OP_READ, 2'b10, 10'd5, 10'd0, 20'h0, lat, rd, er, base);
        check("post_rst_rd5lo", 32'(rd), 32'h00345);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
